// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, least significant first.
// Optional macro BCD_INVALID_DETECT_EN adds the invalid-digit flag on err.
module bcd_serial_addsub #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_n;
   logic [W-1:0]   a_p0, b_p0, acc_p0, acc_n;
   logic           sub_p0, carry_p0;
   logic [CW-1:0]  cnt_p0;
   logic [4:0]     dig_res;
   logic           last, load;

   // Returns {carry, digit} for one decimal digit position.
   function automatic logic [4:0] bcd_digit(input logic [3:0] da, input logic [3:0] db,
                                            input logic s, input logic c);
      logic [3:0] op;
      logic [4:0] t;
      op = s ? (4'd9 - db) : db;
      t  = {1'b0, da} + {1'b0, op} + {4'b0, c};
      if (t > 5'd9) bcd_digit = {1'b1, 4'(t + 5'd6)};
      else          bcd_digit = {1'b0, t[3:0]};
   endfunction

   assign dig_res = bcd_digit(a_p0[3:0], b_p0[3:0], sub_p0, carry_p0);
   assign acc_n   = (acc_p0 >> 4) | (W'(dig_res[3:0]) << (W - 4));
   assign last    = (cnt_p0 == CW'(DIGITS - 1));
   assign load    = start && (state != RUN);
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last)  state_n = DONE;
         DONE:    state_n = start ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Stage p0: operand shift registers, digit carry and result accumulator
   always_ff @(posedge clk) begin
      if (load) begin
         a_p0     <= a;
         b_p0     <= b;
         sub_p0   <= sub;
         carry_p0 <= cin;
         cnt_p0   <= '0;
         acc_p0   <= '0;
      end else if (state == RUN) begin
         a_p0     <= a_p0 >> 4;
         b_p0     <= b_p0 >> 4;
         carry_p0 <= dig_res[4];
         cnt_p0   <= cnt_p0 + CW'(1);
         acc_p0   <= acc_n;
      end
   end

   // Result registers: visible outputs only change when the last digit lands
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (state == RUN && last) begin
         sum  <= acc_n;
         cout <= dig_res[4];
      end
   end

`ifdef BCD_INVALID_DETECT_EN
   logic inv_p0, inv_n, err_r;

   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'd9;
   endfunction

   // Each digit is inspected as it passes through the low nibble.
   assign inv_n = inv_p0 | digit_bad(a_p0[3:0]) | digit_bad(b_p0[3:0]);

   always_ff @(posedge clk) begin
      if (load)               inv_p0 <= 1'b0;
      else if (state == RUN)  inv_p0 <= inv_n;
   end

   always_ff @(posedge clk) begin
      if (rst)                         err_r <= 1'b0;
      else if (state == RUN && last)   err_r <= inv_n;
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule
